// File: rtl/ddr3_frame_rd_ctrl_pkg.sv
// Shared types and helpers for the DDR3 frame read engine.
// State encoding, counter sizing and buffer base address math.
package ddr3_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CMD,
    DRAIN,
    DONE
  } state_e;

  function automatic int cnt_w(input longint max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [63:0] buf_base(
    input logic [63:0] base,
    input logic [63:0] stride,
    input logic [1:0]  sel
  );
    return base + 64'(sel) * stride;
  endfunction

endpackage

// File: rtl/ddr3_frame_rd_ctrl_planner.sv
// Burst planner: clamps the burst to the remaining beats and
// precomputes the post-command address and beat count.
module rd_burst_planner #(
  parameter int ADDR_W     = 28,
  parameter int BL         = 64,
  parameter int BLW        = 17,
  parameter int BEAT_BYTES = 16
) (
  input  logic [BLW-1:0]    beats_left_i,
  input  logic [ADDR_W-1:0] cur_addr_i,
  output logic [6:0]        burst_o,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [BLW-1:0]    next_beats_o
);

  always_comb begin
    burst_o = 7'(beats_left_i);
    if (int'(beats_left_i) >= BL) burst_o = 7'(BL);
  end

  // address arithmetic wraps naturally at 2^ADDR_W
  assign next_addr_o = cur_addr_i
                     + ADDR_W'(burst_o) * ADDR_W'(BEAT_BYTES);

  assign next_beats_o = beats_left_i - BLW'(burst_o);

endmodule

// File: rtl/ddr3_frame_rd_ctrl.sv
// Frame read engine: DDR3 user read port to HDMI pixel cache,
// bursts throttled so outstanding beats never exceed cache space.
module ddr3_frame_rd_ctrl
  import ddr3_rd_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter int                DATA_W      = 128,
  parameter int                BL          = 64,
  parameter int                FRAME_BEATS = 98304,
  parameter int                NUM_BUF     = 2,
  parameter logic [ADDR_W-1:0] BUF_STRIDE  = 28'h0800000,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 28'h0,
  parameter int                SPACE_W     = 10
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              rd_start,
  input  logic [1:0]        buf_sel,
  input  logic [SPACE_W-1:0] cache_space,
  output logic              rd_cmd_en,
  output logic [5:0]        rd_cmd_bl,
  output logic [ADDR_W-1:0] rd_cmd_byte_addr,
  input  logic              rd_cmd_full,
  input  logic              rd_data_empty,
  input  logic [DATA_W-1:0] rd_data_data,
  output logic              rd_data_en,
  output logic              pix_wr_en,
  output logic [DATA_W-1:0] pix_wr_data,
  output logic              rd_end,
  output logic              busy,
  output logic              start_drop
);

  localparam int BEAT_BYTES = beat_bytes(DATA_W);
  localparam int BLW = cnt_w(longint'(FRAME_BEATS));
  localparam int OW  = cnt_w(longint'(BL) * (longint'(1) << SPACE_W));

  if (BL < 1 || BL > 64 || FRAME_BEATS < 1) begin : g_bad_params
    $error("ddr3_frame_rd_ctrl: need 1<=BL<=64 and FRAME_BEATS>=1");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLW-1:0]      beats_q, beats_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic                pix_en_q;
  logic [DATA_W-1:0]   pix_data_q;

  logic [6:0]          burst;
  logic [ADDR_W-1:0]   next_addr;
  logic [BLW-1:0]      next_beats;
  logic [1:0]          sel_m;
  logic [OW:0]         need;
  logic                fits;
  logic                active;
  logic                cmd;
  logic                pop;
  logic                done;

  rd_burst_planner #(
    .ADDR_W     (ADDR_W),
    .BL         (BL),
    .BLW        (BLW),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_planner (
    .beats_left_i (beats_q),
    .cur_addr_i   (addr_q),
    .burst_o      (burst),
    .next_addr_o  (next_addr),
    .next_beats_o (next_beats)
  );

  assign sel_m  = 2'(int'(buf_sel) % NUM_BUF);
  assign need   = {1'b0, outst_q} + (OW+1)'(burst);
  assign fits   = (OW+1)'(cache_space) >= need;
  assign active = state_q inside {ARB, CMD, DRAIN};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    busy_d  = busy_q;
    drop_d  = drop_q;
    cmd     = 1'b0;
    done    = 1'b0;
    pop     = active && init_done && !rd_data_empty
            && (outst_q != '0);

    if (rd_start && state_q != IDLE) drop_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (rd_start && init_done) begin
          addr_d  = ADDR_W'(buf_base(64'(BASE_ADDR),
                                     64'(BUF_STRIDE), sel_m));
          beats_d = BLW'(FRAME_BEATS);
          busy_d  = 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        if (fits && !rd_cmd_full) state_d = CMD;
      end
      CMD: begin
        cmd     = 1'b1;
        addr_d  = next_addr;
        beats_d = next_beats;
        state_d = (next_beats != '0) ? ARB : DRAIN;
      end
      DRAIN: begin
        if (pop && outst_q == OW'(1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    outst_d = outst_q + (cmd ? OW'(burst) : '0)
                      - (pop ? OW'(1) : '0);

    // losing calibration abandons the frame without rd_end
    if (!init_done && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      beats_d = '0;
      outst_d = '0;
      addr_d  = '0;
      cmd     = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      outst_q    <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      pix_en_q   <= 1'b0;
      pix_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      outst_q  <= outst_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      pix_en_q <= pop;
      if (pop) pix_data_q <= rd_data_data;
    end
  end

  assign rd_cmd_en        = cmd;
  assign rd_cmd_bl        = cmd ? 6'(burst - 7'd1) : '0;
  assign rd_cmd_byte_addr = cmd ? addr_q : '0;
  assign rd_data_en       = pop;
  assign pix_wr_en        = pix_en_q;
  assign pix_wr_data      = pix_data_q;
  assign rd_end           = done;
  assign busy             = busy_q;
  assign start_drop       = drop_q;

endmodule

// File: tb/tb_ddr3_frame_rd_ctrl.sv
// Directed bench for ddr3_frame_rd_ctrl: a 200-beat frame engine
// (A) and a 32-beat engine near the top of the address space (B).
module tb_ddr3_frame_rd_ctrl;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        rd_start = 1'b0;
  logic [1:0]  buf_sel = 2'd0;
  logic [9:0]  cache_space = 10'd1023;
  logic        rd_cmd_full = 1'b0;
  logic        rd_data_empty = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [127:0] dat_a, dat_b;

  logic         cmd_en_a, data_en_a, pix_en_a, end_a, busy_a, drop_a;
  logic [5:0]   bl_out_a;
  logic [27:0]  addr_out_a;
  logic [127:0] pix_a;
  logic         cmd_en_b, data_en_b, pix_en_b, end_b, busy_b, drop_b;
  logic [5:0]   bl_out_b;
  logic [27:0]  addr_out_b;
  logic [127:0] pix_b;

  assign dat_a = {96'd0, src_a};
  assign dat_b = {96'd0, src_b};

  always #5 sclk = ~sclk;

  ddr3_frame_rd_ctrl #(
    .FRAME_BEATS (200), .BL (64), .NUM_BUF (2),
    .BUF_STRIDE (28'h0100000), .BASE_ADDR (28'h0)
  ) u_a (
    .sclk (sclk), .rst (rst), .init_done (init_done),
    .rd_start (rd_start), .buf_sel (buf_sel),
    .cache_space (cache_space),
    .rd_cmd_en (cmd_en_a), .rd_cmd_bl (bl_out_a),
    .rd_cmd_byte_addr (addr_out_a), .rd_cmd_full (rd_cmd_full),
    .rd_data_empty (rd_data_empty), .rd_data_data (dat_a),
    .rd_data_en (data_en_a), .pix_wr_en (pix_en_a),
    .pix_wr_data (pix_a), .rd_end (end_a), .busy (busy_a),
    .start_drop (drop_a)
  );

  ddr3_frame_rd_ctrl #(
    .FRAME_BEATS (32), .BL (16), .NUM_BUF (2),
    .BASE_ADDR (28'hFFFFF00)
  ) u_b (
    .sclk (sclk), .rst (rst), .init_done (init_done),
    .rd_start (rd_start), .buf_sel (buf_sel),
    .cache_space (cache_space),
    .rd_cmd_en (cmd_en_b), .rd_cmd_bl (bl_out_b),
    .rd_cmd_byte_addr (addr_out_b), .rd_cmd_full (rd_cmd_full),
    .rd_data_empty (rd_data_empty), .rd_data_data (dat_b),
    .rd_data_en (data_en_b), .pix_wr_en (pix_en_b),
    .pix_wr_data (pix_b), .rd_end (end_b), .busy (busy_b),
    .start_drop (drop_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // read-data FIFO model: sequential beat numbers per engine
  always @(posedge sclk) begin
    if (clr) begin
      src_a <= '0;
      src_b <= '0;
    end else begin
      if (data_en_a) src_a <= src_a + 32'd1;
      if (data_en_b) src_b <= src_b + 32'd1;
    end
  end

  int          mc_a, mp_a, me_a, mat_a, derr_a, pops_a, iss_a, ovf_a;
  logic [27:0] adr_a [8];
  logic [5:0]  bls_a [8];
  int          mc_b, mp_b, me_b, mat_b;
  logic [27:0] adr_b [4];
  logic [5:0]  bls_b [4];

  always @(negedge sclk) begin
    if (clr) begin
      mc_a <= 0; mp_a <= 0; me_a <= 0; mat_a <= -1;
      derr_a <= 0; pops_a <= 0; iss_a <= 0; ovf_a <= 0;
    end else begin
      if (cmd_en_a) begin
        if (iss_a - pops_a + int'(bl_out_a) + 1 > int'(cache_space))
          ovf_a <= ovf_a + 1;
        if (mc_a < 8) begin
          adr_a[mc_a] <= addr_out_a;
          bls_a[mc_a] <= bl_out_a;
        end
        mc_a  <= mc_a + 1;
        iss_a <= iss_a + int'(bl_out_a) + 1;
      end
      if (data_en_a) pops_a <= pops_a + 1;
      if (pix_en_a) begin
        if (pix_a !== {96'd0, 32'(mp_a)}) derr_a <= derr_a + 1;
        mp_a <= mp_a + 1;
      end
      if (end_a) begin
        me_a  <= me_a + 1;
        mat_a <= pix_en_a ? mp_a + 1 : -1;
      end
    end
  end

  always @(negedge sclk) begin
    if (clr) begin
      mc_b <= 0; mp_b <= 0; me_b <= 0; mat_b <= -1;
    end else begin
      if (cmd_en_b) begin
        if (mc_b < 4) begin
          adr_b[mc_b] <= addr_out_b;
          bls_b[mc_b] <= bl_out_b;
        end
        mc_b <= mc_b + 1;
      end
      if (pix_en_b) mp_b <= mp_b + 1;
      if (end_b) begin
        me_b  <= me_b + 1;
        mat_b <= pix_en_b ? mp_b + 1 : -1;
      end
    end
  end

  task automatic clear_mon();
    @(posedge sclk); #2 clr = 1'b1;
    @(posedge sclk); #2 clr = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] sel);
    @(negedge sclk);
    buf_sel  = sel;
    rd_start = 1'b1;
    @(negedge sclk);
    rd_start = 1'b0;
  endtask

  task automatic wait_a(input string tag);
    int n = 0;
    while (busy_a && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    chk(tag, 64'(busy_a), 64'd0);
    repeat (3) @(negedge sclk);
  endtask

  task automatic wait_b(input string tag);
    int n = 0;
    while (busy_b && n < 1000) begin
      @(negedge sclk);
      n++;
    end
    chk(tag, 64'(busy_b), 64'd0);
    repeat (3) @(negedge sclk);
  endtask

  task automatic check_frame_a(input string p);
    logic [27:0] ea [4];
    logic [5:0]  eb [4];
    ea = '{28'h0100000, 28'h0100400, 28'h0100800, 28'h0100C00};
    eb = '{6'd63, 6'd63, 6'd63, 6'd7};
    chk({p, "_ncmd"}, 64'(mc_a), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_adr%0d", p, i), 64'(adr_a[i]), 64'(ea[i]));
      chk($sformatf("%s_bl%0d", p, i), 64'(bls_a[i]), 64'(eb[i]));
    end
    chk({p, "_npix"}, 64'(mp_a), 64'd200);
    chk({p, "_nend"}, 64'(me_a), 64'd1);
    chk({p, "_endat"}, 64'(mat_a), 64'd200);
    chk({p, "_data"}, 64'(derr_a), 64'd0);
    chk({p, "_ovf"}, 64'(ovf_a), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seen;
    int n;
    clear_mon();
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    chk("rst_outs", 64'({busy_a, cmd_en_a, data_en_a, pix_en_a,
                         end_a, drop_a, |pix_a, |addr_out_a}), 64'd0);

    start_frame(2'd1);
    repeat (2) @(negedge sclk);
    chk("no_init_busy", 64'(busy_a), 64'd0);
    chk("no_init_drop", 64'(drop_a), 64'd0);

    init_done     = 1'b1;
    rd_data_empty = 1'b0;

    clear_mon();
    start_frame(2'd1);
    wait_a("t1_to");
    check_frame_a("t1");

    cache_space   = 10'd70;
    rd_data_empty = 1'b1;
    clear_mon();
    start_frame(2'd1);
    repeat (30) @(negedge sclk);
    chk("t2_hold", 64'(mc_a), 64'd1);
    rd_data_empty = 1'b0;
    wait_a("t2_to");
    check_frame_a("t2");
    cache_space = 10'd1023;

    clear_mon();
    start_frame(2'd1);
    n = 0;
    while (!cmd_en_a && n < 100) begin
      @(negedge sclk);
      n++;
    end
    rd_cmd_full = 1'b1;
    w = 0;
    repeat (20) begin
      @(negedge sclk);
      if (cmd_en_a) w++;
    end
    chk("t3_window", 64'(w), 64'd0);
    rd_cmd_full = 1'b0;
    wait_a("t3_to");
    check_frame_a("t3");

    clear_mon();
    start_frame(2'd1);
    repeat (20) @(negedge sclk);
    buf_sel  = 2'd0;
    rd_start = 1'b1;
    @(negedge sclk);
    rd_start = 1'b0;
    chk("t4_drop", 64'(drop_a), 64'd1);
    wait_a("t4_to");
    repeat (10) @(negedge sclk);
    check_frame_a("t4");
    chk("t4_idle", 64'(busy_a), 64'd0);
    chk("t4_sticky", 64'(drop_a), 64'd1);
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    chk("t4_rst_drop", 64'(drop_a), 64'd0);

    clear_mon();
    start_frame(2'd1);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 400) begin
      @(negedge sclk);
      if (cmd_en_a) seen++;
      n++;
    end
    @(negedge sclk);
    init_done = 1'b0;
    @(negedge sclk);
    chk("t5_busy", 64'(busy_a), 64'd0);
    w = 0;
    repeat (5) begin
      @(negedge sclk);
      if (data_en_a || cmd_en_a) w++;
    end
    chk("t5_quiet", 64'(w), 64'd0);
    chk("t5_noend", 64'(me_a), 64'd0);
    init_done = 1'b1;
    clear_mon();
    start_frame(2'd3);
    wait_a("t5_to");
    check_frame_a("t5");

    clear_mon();
    start_frame(2'd0);
    wait_b("t6_to");
    chk("t6_ncmd", 64'(mc_b), 64'd2);
    chk("t6_adr0", 64'(adr_b[0]), 64'h0FFFFF00);
    chk("t6_adr1", 64'(adr_b[1]), 64'h0);
    chk("t6_bl0", 64'(bls_b[0]), 64'd15);
    chk("t6_bl1", 64'(bls_b[1]), 64'd15);
    chk("t6_npix", 64'(mp_b), 64'd32);
    chk("t6_nend", 64'(me_b), 64'd1);
    chk("t6_endat", 64'(mat_b), 64'd32);
    wait_a("t6_a_to");

    start_frame(2'd0);
    n = 0;
    while (!pix_en_b && n < 100) begin
      @(negedge sclk);
      n++;
    end
    chk("t6_midburst", 64'(pix_en_b), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_arst_b", 64'({busy_b, cmd_en_b, data_en_b, pix_en_b,
                          end_b, drop_b, |pix_b, |addr_out_b,
                          |bl_out_b}), 64'd0);
    chk("t6_arst_a", 64'({busy_a, cmd_en_a, data_en_a, pix_en_a,
                          end_a}), 64'd0);
    @(negedge sclk);
    rst = 1'b0;
    repeat (2) @(negedge sclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
